// File: rtl/arb_mux_nx1.sv
// rtl/arb_mux_nx1.sv - N-to-1 stream arbiter/mux with a registered output stage.
// Arbitration is fixed priority (lowest index) by default; define ARB_MUX_RR_EN for round-robin.
module arb_mux_nx1 #(
    parameter int NUM_OF_INPUTS = 5,
    parameter int INPUT_WIDTH   = 4,
    localparam int SW           = $clog2(NUM_OF_INPUTS)
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [INPUT_WIDTH*NUM_OF_INPUTS-1:0] in_data,
    input  logic [NUM_OF_INPUTS-1:0]             in_valid,
    output logic [NUM_OF_INPUTS-1:0]             in_ready,
    output logic [INPUT_WIDTH-1:0]               out_data,
    output logic [SW-1:0]                        out_sel,
    output logic                                 out_valid,
    input  logic                                 out_ready
);

    logic                   out_valid_q, out_valid_d;
    logic [INPUT_WIDTH-1:0] out_data_q, out_data_d;
    logic [SW-1:0]          out_sel_q, out_sel_d;

    logic                   load_en;
    logic                   grant_found;
    logic [SW-1:0]          grant_idx;
    logic [INPUT_WIDTH-1:0] grant_data;

    assign load_en = !out_valid_q || out_ready;

`ifdef ARB_MUX_RR_EN
    logic [SW-1:0] last_grant_q, last_grant_d;
    logic [SW:0]   cand;

    // Search starts one past the last winner and wraps at NUM_OF_INPUTS, not at 2^SW.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= NUM_OF_INPUTS; k++) begin
            cand = {1'b0, last_grant_q} + (SW+1)'(k);
            if (cand >= (SW+1)'(NUM_OF_INPUTS)) begin
                cand = cand - (SW+1)'(NUM_OF_INPUTS);
            end
            if (!grant_found && in_valid[cand[SW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[SW-1:0];
            end
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (load_en && grant_found) begin
            last_grant_d = grant_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant_q <= SW'(NUM_OF_INPUTS - 1);
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`else
    // Descending scan so the lowest asserted index is the final winner.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = NUM_OF_INPUTS - 1; i >= 0; i--) begin
            if (in_valid[i]) begin
                grant_found = 1'b1;
                grant_idx   = SW'(i);
            end
        end
    end
`endif

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < NUM_OF_INPUTS; i++) begin
            if (grant_idx == SW'(i)) begin
                grant_data = in_data[i*INPUT_WIDTH +: INPUT_WIDTH];
            end
        end
    end

    // in_ready depends only on valids, out_ready and state; in_data feeds only the register.
    always_comb begin
        in_ready = '0;
        if (rst_n && load_en && grant_found) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        if (load_en) begin
            if (grant_found) begin
                out_valid_d = 1'b1;
                out_data_d  = grant_data;
                out_sel_d   = grant_idx;
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_arb_mux_nx1.sv
// tb/tb_arb_mux_nx1.sv - self-checking bench for arb_mux_nx1 with a beat scoreboard.
module tb_arb_mux_nx1;

    localparam int N  = 5;
    localparam int W  = 4;
    localparam int SW = 3;

    typedef struct packed {
        logic [SW-1:0] sel;
        logic [W-1:0]  data;
    } beat_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N*W-1:0]   in_data;
    logic [N-1:0]     in_valid;
    logic [N-1:0]     in_ready;
    logic [W-1:0]     out_data;
    logic [SW-1:0]    out_sel;
    logic             out_valid;
    logic             out_ready;

    beat_t            exp_q[$];
    int               m_last = N - 1;
    logic [W-1:0]     m_hold_data = '0;
    logic [SW-1:0]    m_hold_sel = '0;
    int               tests_run = 0;
    int               tests_failed = 0;

    always #5 clk = ~clk;

    arb_mux_nx1 #(.NUM_OF_INPUTS(N), .INPUT_WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_sel(out_sel),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    function automatic int model_winner(input logic [N-1:0] v);
`ifdef ARB_MUX_RR_EN
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (m_last + k) % N;
            if (v[i]) return i;
        end
`else
        for (int i = 0; i < N; i++) begin
            if (v[i]) return i;
        end
`endif
        return -1;
    endfunction

    function automatic logic [N-1:0] model_ready();
        logic [N-1:0] r;
        int g;
        r = '0;
        if (!rst_n) return r;
        if (exp_q.size() != 0 && !out_ready) return r;
        g = model_winner(in_valid);
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    function automatic logic [SW+W:0] model_out();
        if (exp_q.size() != 0) return {1'b1, exp_q[0]};
        return {1'b0, m_hold_sel, m_hold_data};
    endfunction

    task automatic drive(input logic [N-1:0] v, input logic [N*W-1:0] d,
                         input logic ordy, input logic rstn);
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        rst_n     = rstn;
        #1;
    endtask

    task automatic tick();
        logic [N-1:0] r;
        int           g;
        logic         ovld;
        beat_t        b;
        r    = model_ready();
        g    = model_winner(in_valid);
        ovld = (exp_q.size() != 0);
        b    = '0;
        if (g >= 0) begin
            b.sel  = SW'(g);
            b.data = in_data[g*W +: W];
        end
        @(posedge clk);
        if (!rst_n) begin
            exp_q.delete();
            m_last      = N - 1;
            m_hold_data = '0;
            m_hold_sel  = '0;
        end else begin
            if (ovld && out_ready) void'(exp_q.pop_front());
            if (r != '0) begin
                exp_q.push_back(b);
                m_last      = g;
                m_hold_data = b.data;
                m_hold_sel  = b.sel;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        drive('0, '0, 1'b1, 1'b0);
        tick();
    endtask

    task automatic test_reset();
        drive('1, (N*W)'($urandom), 1'b1, 1'b0);
        tests_run++;
        if (in_ready !== '0) begin
            tests_failed++;
            $display("FAIL reset_in_ready: got %b want 0", in_ready);
        end
        tick();
        tests_run++;
        if ({out_valid, out_sel, out_data} !== {1'b0, 3'd0, 4'd0}) begin
            tests_failed++;
            $display("FAIL reset_out: got v=%b sel=%0d d=%h want 0/0/0", out_valid, out_sel, out_data);
        end
    endtask

    task automatic test_single_beat();
        drive(5'b00100, 20'h00A00, 1'b1, 1'b1);
        tests_run++;
        if (in_ready !== 5'b00100) begin
            tests_failed++;
            $display("FAIL single_in_ready: got %b want 00100", in_ready);
        end
        tick();
        tests_run++;
        if ({out_valid, out_sel, out_data} !== {1'b1, 3'd2, 4'hA} || model_out() !== {1'b1, 3'd2, 4'hA}) begin
            tests_failed++;
            $display("FAIL single_out: got v=%b sel=%0d d=%h want 1/2/a", out_valid, out_sel, out_data);
        end
        drive('0, '0, 1'b1, 1'b1);
        tick();
        tests_run++;
        if ({out_valid, out_sel, out_data} !== {1'b0, 3'd2, 4'hA}) begin
            tests_failed++;
            $display("FAIL idle_hold: got v=%b sel=%0d d=%h want 0/2/a", out_valid, out_sel, out_data);
        end
    endtask

    task automatic test_backpressure();
        logic [N-1:0] r;
        drive(5'b00010, 20'h00050, 1'b1, 1'b1);
        tick();
        for (int c = 0; c < 3; c++) begin
            drive('1, (N*W)'($urandom), 1'b0, 1'b1);
            tests_run++;
            if (in_ready !== '0) begin
                tests_failed++;
                $display("FAIL stall_in_ready[%0d]: got %b want 0", c, in_ready);
            end
            tick();
            tests_run++;
            if ({out_valid, out_sel, out_data} !== {1'b1, 3'd1, 4'h5}) begin
                tests_failed++;
                $display("FAIL stall_hold[%0d]: got v=%b sel=%0d d=%h want 1/1/5", c, out_valid, out_sel, out_data);
            end
        end
        drive('1, (N*W)'($urandom), 1'b1, 1'b1);
        r = model_ready();
        tests_run++;
        if (in_ready !== r || r == '0) begin
            tests_failed++;
            $display("FAIL release_grant: got %b want %b", in_ready, r);
        end
        tick();
        tests_run++;
        if ({out_valid, out_sel, out_data} !== model_out()) begin
            tests_failed++;
            $display("FAIL release_out: got %h want %h", {out_valid, out_sel, out_data}, model_out());
        end
    endtask

    task automatic run_sel_seq(input string name, input logic [N-1:0] v, input int seq[6], input int len);
        logic [N-1:0] r;
        for (int c = 0; c < len; c++) begin
            drive(v, (N*W)'($urandom), 1'b1, 1'b1);
            r = model_ready();
            tests_run++;
            if (in_ready !== r) begin
                tests_failed++;
                $display("FAIL %s_in_ready[%0d]: got %b want %b", name, c, in_ready, r);
            end
            tick();
            tests_run++;
            if (out_valid !== 1'b1 || int'(out_sel) != seq[c] || {out_valid, out_sel, out_data} !== model_out()) begin
                tests_failed++;
                $display("FAIL %s_sel[%0d]: got v=%b sel=%0d d=%h want sel=%0d", name, c, out_valid, out_sel, out_data, seq[c]);
            end
        end
    endtask

    task automatic test_arbitration();
`ifdef ARB_MUX_RR_EN
        int all_seq[6]  = '{0, 1, 2, 3, 4, 0};
        int part_seq[6] = '{1, 3, 4, 1, 3, 4};
        int wrap_seq[6] = '{0, 4, 0, 0, 0, 0};
`else
        int all_seq[6]  = '{0, 0, 0, 0, 0, 0};
        int part_seq[6] = '{1, 1, 1, 1, 1, 1};
        int wrap_seq[6] = '{0, 0, 0, 0, 0, 0};
`endif
        do_reset();
        run_sel_seq("all", 5'b11111, all_seq, 6);
        run_sel_seq("part", 5'b11010, part_seq, 6);
        do_reset();
        run_sel_seq("wrap", 5'b10001, wrap_seq, 3);
    endtask

    task automatic test_reset_mid_stall();
        drive(5'b01000, 20'h07000, 1'b1, 1'b1);
        tick();
        drive('1, (N*W)'($urandom), 1'b0, 1'b1);
        tick();
        drive('1, (N*W)'($urandom), 1'b0, 1'b0);
        tests_run++;
        if (in_ready !== '0) begin
            tests_failed++;
            $display("FAIL midstall_in_ready: got %b want 0", in_ready);
        end
        tick();
        tests_run++;
        if ({out_valid, out_sel, out_data} !== {1'b0, 3'd0, 4'd0}) begin
            tests_failed++;
            $display("FAIL midstall_out: got v=%b sel=%0d d=%h want 0/0/0", out_valid, out_sel, out_data);
        end
        for (int c = 0; c < 2; c++) begin
            drive('0, '0, 1'b1, 1'b1);
            tick();
            tests_run++;
            if ({out_valid, out_sel, out_data} !== {1'b0, 3'd0, 4'd0}) begin
                tests_failed++;
                $display("FAIL midstall_ghost[%0d]: got v=%b sel=%0d d=%h want 0/0/0", c, out_valid, out_sel, out_data);
            end
        end
    endtask

    task automatic test_random();
        logic [N-1:0] r;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            drive(N'($urandom), (N*W)'($urandom), ($urandom % 4) != 0, ($urandom % 60) != 0);
            r = model_ready();
            tests_run++;
            if (in_ready !== r) begin
                tests_failed++;
                $display("FAIL rand_in_ready[%0d]: got %b want %b", c, in_ready, r);
            end
            tick();
            tests_run++;
            if ({out_valid, out_sel, out_data} !== model_out()) begin
                tests_failed++;
                $display("FAIL rand_out[%0d]: got %h want %h", c, {out_valid, out_sel, out_data}, model_out());
            end
        end
    endtask

    initial begin
        in_valid  = '0;
        in_data   = '0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        test_reset();
        test_single_beat();
        test_backpressure();
        test_arbitration();
        test_reset_mid_stall();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
